// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: forwarding-select encodings, the default
// register address width and the per-source select helper.
package cpu_pkg;

  localparam int REG_ADDR_W_DEFAULT = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Forwarding priority for one source: the EX result is younger than the
  // returning load data, so it wins when both match the same register.
  function automatic logic [1:0] fwd_pick(input logic used,
                                          input logic ex_hit,
                                          input logic mem_hit);
    logic [1:0] sel;
    sel = FWD_RF;
    if (used) begin
      if (ex_hit) begin
        sel = FWD_EX;
      end else if (mem_hit) begin
        sel = FWD_MEM;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Bundle between the ID stage (master) and the hazard scoreboard (slave).
// src_addr and fwd_sel carry source 0 in their most significant slice;
// src_used bit s belongs to source s.
interface hazard_scoreboard_if
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT,
  parameter int NUM_SRC    = 2,
  parameter int LQ_DEPTH   = 4
);

  localparam int CNT_W = $clog2(LQ_DEPTH) + 1;

  logic                          issue_valid;
  logic                          issue_wr_en;
  logic                          issue_is_load;
  logic [REG_ADDR_W-1:0]         issue_rd;
  logic [NUM_SRC-1:0]            src_used;
  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr;
  logic                          mem_ack;
  logic                          stall;
  logic [2*NUM_SRC-1:0]          fwd_sel;
  logic                          wb_en;
  logic [REG_ADDR_W-1:0]         wb_rd;
  logic [CNT_W-1:0]              lq_count;
  logic                          lq_full;
  logic                          ack_err;
  logic [31:0]                   perf_stall_cnt;
  logic [31:0]                   perf_load_cnt;

  modport master (
    output issue_valid, issue_wr_en, issue_is_load, issue_rd,
           src_used, src_addr, mem_ack,
    input  stall, fwd_sel, wb_en, wb_rd, lq_count, lq_full, ack_err,
           perf_stall_cnt, perf_load_cnt
  );

  modport slave (
    input  issue_valid, issue_wr_en, issue_is_load, issue_rd,
           src_used, src_addr, mem_ack,
    output stall, fwd_sel, wb_en, wb_rd, lq_count, lq_full, ack_err,
           perf_stall_cnt, perf_load_cnt
  );

endinterface

// File: rtl/load_dest_queue.sv
// In-order FIFO of outstanding load destinations with a parallel
// address-match port per query. The head entry is hidden from the match
// ports in the cycle it is popped, since its data is arriving right now.
module load_dest_queue
  import cpu_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W_DEFAULT,
  parameter int DEPTH  = 4,
  parameter int NUM_Q  = 3,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [ADDR_W-1:0]       push_rd,
  input  logic                    pop,
  input  logic [NUM_Q*ADDR_W-1:0] query,    // query q at [q*ADDR_W +: ADDR_W]
  output logic [NUM_Q-1:0]        match,
  output logic [ADDR_W-1:0]       head_rd,
  output logic [CNT_W-1:0]        count,
  output logic                    full,
  output logic                    empty
);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DEPTH-1:0]  live;
  logic              pop_ok;
  logic              push_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A push into a full queue is only legal when the head leaves this cycle.
  assign push_ok = push && (!full || pop_ok);
  assign head_rd = mem_q[rd_ptr_q];
  assign count   = cnt_q;

  // Pointer, occupancy and storage next-state; the push is applied after the
  // pop so a full-queue push/pop into the same slot leaves it occupied.
  always_comb begin
    mem_d    = mem_q;
    vld_d    = vld_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (pop_ok) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_rd;
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Entries visible to the match ports: the acked head has already left.
  always_comb begin
    live = vld_q;
    if (pop_ok) begin
      live[rd_ptr_q] = 1'b0;
    end
  end

  for (genvar gi = 0; gi < NUM_Q; gi++) begin : g_match
    logic [DEPTH-1:0] hit;
    // Compare one query address against every live entry.
    always_comb begin
      hit = '0;
      for (int i = 0; i < DEPTH; i++) begin
        hit[i] = live[i] && (mem_q[i] == query[gi*ADDR_W +: ADDR_W]);
      end
    end
    assign match[gi] = |hit;
  end

  // Queue state registers, fully cleared while reset is low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      vld_q    <= vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller between ID and the RF/ALU. Tracks the
// single ALU writer in EX and up to LQ_DEPTH outstanding loads, and derives
// the ID stall, per-source forwarding selects and the load write-back.
// Optional performance counters are built when HAZARD_SCOREBOARD_PERF_EN
// is defined; otherwise the counter outputs read as zero.
module hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT,
  parameter int NUM_SRC    = 2,
  parameter int LQ_DEPTH   = 4
) (
  input logic                clk,
  input logic                reset,
  hazard_scoreboard_if.slave bus
);

  localparam int CNT_W = $clog2(LQ_DEPTH) + 1;
  localparam int NUM_Q = NUM_SRC + 1;

  logic                        ex_valid_q, ex_valid_d;
  logic [REG_ADDR_W-1:0]       ex_rd_q, ex_rd_d;
  logic                        ack_err_q, ack_err_d;

  logic [REG_ADDR_W-1:0]       src_a [NUM_SRC];
  logic [NUM_Q*REG_ADDR_W-1:0] q_query;
  logic [NUM_Q-1:0]            q_match;
  logic [REG_ADDR_W-1:0]       q_head;
  logic [CNT_W-1:0]            q_count;
  logic                        q_full;
  logic                        q_empty;

  logic                        wb_en_w;
  logic                        pop_w;
  logic                        push_w;
  logic                        accept_w;
  logic                        raw_w;
  logic                        waw_w;
  logic                        cap_w;
  logic                        stall_w;
  logic [2*NUM_SRC-1:0]        fwd_w;

  // Unpack source addresses: source 0 sits in the top slice of src_addr.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign src_a[gi] = bus.src_addr[(NUM_SRC-gi)*REG_ADDR_W-1 -: REG_ADDR_W];
  end

  // Query layout for the queue: one port per source, then issue_rd for WAW.
  always_comb begin
    q_query = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      q_query[s*REG_ADDR_W +: REG_ADDR_W] = src_a[s];
    end
    q_query[NUM_SRC*REG_ADDR_W +: REG_ADDR_W] = bus.issue_rd;
  end

  load_dest_queue #(
    .ADDR_W (REG_ADDR_W),
    .DEPTH  (LQ_DEPTH),
    .NUM_Q  (NUM_Q)
  ) u_lq (
    .clk     (clk),
    .reset   (reset),
    .push    (push_w),
    .push_rd (bus.issue_rd),
    .pop     (pop_w),
    .query   (q_query),
    .match   (q_match),
    .head_rd (q_head),
    .count   (q_count),
    .full    (q_full),
    .empty   (q_empty)
  );

  // Stall, accept and write-back decisions; all forced quiet during reset.
  always_comb begin
    pop_w   = reset && bus.mem_ack;
    wb_en_w = pop_w && !q_empty;
    raw_w   = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      raw_w = raw_w || (bus.src_used[s] && q_match[s]);
    end
    waw_w    = bus.issue_wr_en && q_match[NUM_SRC];
    cap_w    = bus.issue_is_load && q_full && !bus.mem_ack;
    stall_w  = reset && bus.issue_valid && (raw_w || waw_w || cap_w);
    accept_w = reset && bus.issue_valid && !stall_w;
    push_w   = accept_w && bus.issue_is_load;
  end

  // Per-source forwarding selects; source 0 occupies the top two bits.
  always_comb begin
    fwd_w = '0;
    if (reset) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        fwd_w[(NUM_SRC-s)*2-1 -: 2] = fwd_pick(bus.src_used[s],
                                               ex_valid_q && (ex_rd_q == src_a[s]),
                                               wb_en_w && (q_head == src_a[s]));
      end
    end
  end

  // Next EX slot content and sticky ack error.
  always_comb begin
    ex_valid_d = accept_w && bus.issue_wr_en && !bus.issue_is_load;
    ex_rd_d    = ex_valid_d ? bus.issue_rd : '0;
    ack_err_d  = ack_err_q || (bus.mem_ack && q_empty);
  end

  // EX slot and error flag registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_valid_q <= 1'b0;
      ex_rd_q    <= '0;
      ack_err_q  <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_rd_q    <= ex_rd_d;
      ack_err_q  <= ack_err_d;
    end
  end

  assign bus.stall    = stall_w;
  assign bus.fwd_sel  = fwd_w;
  assign bus.wb_en    = wb_en_w;
  assign bus.wb_rd    = wb_en_w ? q_head : '0;
  assign bus.lq_count = q_count;
  assign bus.lq_full  = q_full;
  assign bus.ack_err  = ack_err_q;

`ifdef HAZARD_SCOREBOARD_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_load_q, perf_load_d;

  // Saturating event counters.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_load_d  = perf_load_q;
    if (stall_w && (perf_stall_q != 32'hFFFF_FFFF)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if (push_w && (perf_load_q != 32'hFFFF_FFFF)) begin
      perf_load_d = perf_load_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_stall_q <= '0;
      perf_load_q  <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_load_q  <= perf_load_d;
    end
  end

  assign bus.perf_stall_cnt = perf_stall_q;
  assign bus.perf_load_cnt  = perf_load_q;
`else
  assign bus.perf_stall_cnt = '0;
  assign bus.perf_load_cnt  = '0;
`endif

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding controller for the in-order CPU pipeline. Sits between the instruction decoder (ID) and the register file/ALU.
- Tracks in-flight register writers: one ALU writer in EX, plus up to LQ_DEPTH outstanding loads whose data memory may answer with variable latency.
- From these it produces the ID-stage stall, per-source forwarding selects, and the load write-back address.
- Generalises the fixed 2-source, fixed-latency, single-load scheme to N sources, a multi-entry in-order load queue, and WAW protection.

## Interface
Parameters:
- REG_ADDR_W, 5, register address width
- NUM_SRC, 2, source operands checked per instruction (1..4)
- LQ_DEPTH, 4, max outstanding loads (power of two, 2..16)

Ports:
- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-low; all state cleared on the rising clk edge while low
- issue_valid  in  1  decoded instruction present in ID
- issue_wr_en  in  1  instruction writes issue_rd (ALU, SFU or load)
- issue_is_load  in  1  instruction is a load
- issue_rd  in  REG_ADDR_W  destination register
- src_used  in  NUM_SRC  per-source "operand read" flags
- src_addr  in  NUM_SRC*REG_ADDR_W  source addresses; source 0 in the MSB-first slice
- mem_ack  in  1  data memory returns data for the oldest outstanding load this cycle
- stall  out  1  hold IF/ID and insert a bubble into EX
- fwd_sel  out  2*NUM_SRC  per source: 00 RF, 01 EX ALU result, 10 memory data in; 11 never driven
- wb_en  out  1  write load data to RF this cycle
- wb_rd  out  REG_ADDR_W  destination for the load write-back
- lq_count  out  $clog2(LQ_DEPTH)+1  outstanding loads
- lq_full  out  1  lq_count == LQ_DEPTH
- ack_err  out  1  sticky; mem_ack seen with empty queue
- perf_stall_cnt  out  32  stall cycles (see Configuration)
- perf_load_cnt  out  32  loads accepted (see Configuration)

## Operation
- **Accept:** an instruction is accepted when issue_valid && !stall.
- **EX slot:** records {valid, rd} of an accepted non-load writer for exactly one cycle. A bubble is inserted when not accepted.
- **Load queue:** an accepted load pushes issue_rd into the in-order load queue. mem_ack pops the head.
- **Write-back:** wb_en = mem_ack && lq_count != 0, and wb_rd = head rd, both combinational.
- **Stall sources** (OR of the following, all qualified by issue_valid):
  - **RAW:** a used source matches any queue entry, excluding the head when it is acked this cycle.
  - **WAW:** issue_wr_en && issue_rd matches any queue entry, excluding the head when it is acked this cycle.
  - **Capacity:** issue_is_load && lq_full && !mem_ack.
- **Forwarding, per used source, first match wins:**
  - EX slot valid and rd match → 01.
  - Head acked this cycle and rd match → 10.
  - Otherwise → 00.
  - Unused sources → 00.
- **Simultaneous events:**
  - Push and pop in the same cycle: count unchanged and both pointers advance. This is legal even when the queue is full.
  - mem_ack with an empty queue: ignored, and ack_err is set until reset.
- **Reset mid-operation:** the queue, EX slot, ack_err and counters are cleared. Outstanding acks after reset count as errors.

## Timing
- stall, fwd_sel, wb_en and wb_rd are combinational from the current-cycle inputs and registered state. They take effect in the same cycle.
- EX slot and queue update on the rising clk edge.
- An ALU result is forwardable for exactly the one cycle after issue. After that it is in the RF.
- Load-use distance is at least 1 cycle after issue. The consumer stalls until the ack cycle, then proceeds with select 10.
- Reset values of registered state: EX slot invalid, lq_count 0, lq_full 0, ack_err 0, perf counters 0.
- While reset is low, all outputs are forced: stall 0, fwd_sel 0, wb_en 0, wb_rd 0.

## Configuration
- Macro `HAZARD_SCOREBOARD_PERF_EN`.
- **Defined:** perf_stall_cnt increments on every cycle with stall=1, and perf_load_cnt increments on every accepted load. Both saturate at 0xFFFFFFFF.
- **Undefined:** the ports remain, tied to 0, and no counter flops are built.

## Structure
- Shared package cpu_pkg: FWD_RF, FWD_EX and FWD_MEM 2-bit constants; REG_ADDR_W default.
- Sub-module load_dest_queue: a parametrised FIFO of rd values providing push, pop, head, count, full, and a parallel match vector against a query address. It is instantiated once, with NUM_SRC+1 match ports.

## Test plan
- ALU r3 accepted, next cycle ALU with src r3 → stall=0, fwd_sel[src]=01. The following cycle src r3 → 00.
- Load r5, then consumer src r5 with no ack → stall=1 each cycle. In the mem_ack cycle → stall=0, fwd_sel=10, wb_en=1, wb_rd=5.
- 4 loads (r1..r4) accepted, 5th load without ack → stall=1 and lq_full=1. With mem_ack in the same cycle → accepted, lq_count stays 4, wb_rd=1.
- Load r7 pending, ALU writing r7 → stall=1 (WAW) until the ack cycle, then accepted.
- mem_ack with empty queue → wb_en=0 and ack_err=1, held until reset.
- 3 loads outstanding, reset low for 1 cycle → lq_count=0, no stall on a consumer of r1. With PERF_EN defined, counters read 0.
